// File: rtl/gal_olmc_bank_reg.sv
// Bank of GAL output logic macrocells. A serial fuse stream sets REGISTERED/INVERTED
// per cell, and the cells then drive the pins and the array feedback.
module gal_olmc_bank_reg #(
  parameter int N_OLMC = 8,
  parameter int CNT_W  = 5
) (
  input  logic              C,
  input  logic              AR_N,
  input  logic [N_OLMC-1:0] A,
  output logic [N_OLMC-1:0] Y,
  output logic [N_OLMC-1:0] FB,
  input  logic              CFG_START,
  input  logic              CFG_D,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  output logic              CFG_DONE
);

  localparam int SW = 2 * N_OLMC;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     shadow_q, shadow_d;
  logic [SW-1:0]     active_q, active_d;
  logic [N_OLMC-1:0] q_q, q_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              xfer;
  logic              restart;
  logic [SW-1:0]     bit_mask;
  logic [N_OLMC-1:0] reg_mode;
  logic [N_OLMC-1:0] inv_mode;
  logic [N_OLMC-1:0] y_int;

  assign xfer    = CFG_VALID & ready_q;
  assign restart = CFG_START & (state_q != S_APPLY);

  // Even fuse bits select REGISTERED, odd bits select INVERTED.
  always_comb begin
    reg_mode = '0;
    inv_mode = '0;
    for (int i = 0; i < N_OLMC; i++) begin
      reg_mode[i] = active_q[2*i];
      inv_mode[i] = active_q[2*i+1];
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = done_q;
    q_d      = q_q;
    bit_mask = '0;

    if (restart) begin
      cnt_d    = '0;
      shadow_d = '0;
    end

    // A bit accepted alongside CFG_START lands at index 0 because cnt_d was just cleared.
    if (xfer) begin
      bit_mask = SW'(1) << cnt_d;
      shadow_d = CFG_D ? (shadow_d | bit_mask) : (shadow_d & ~bit_mask);
      cnt_d    = cnt_d + CNT_W'(1);
    end

    case (state_q)
      S_IDLE, S_RUN: begin
        if (restart || xfer) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (xfer && !restart && (cnt_q == LAST_IDX)) begin
          state_d = S_APPLY;
          cnt_d   = '0;
        end
      end
      S_APPLY: begin
        active_d = shadow_q;
        done_d   = 1'b1;
        state_d  = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    // The old configuration keeps running through a reload; APPLY starts from cleared cells.
    if (state_q == S_APPLY) begin
      q_d = '0;
    end else if (done_q) begin
      q_d = A & reg_mode;
    end
  end

  assign ready_d = (state_d != S_APPLY);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge C or negedge AR_N) begin
    if (!AR_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      q_q      <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      q_q      <= q_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign y_int = done_q ? (((reg_mode & q_q) | (~reg_mode & A)) ^ inv_mode) : '0;

  assign Y         = y_int;
  assign FB        = done_q ? ((reg_mode & q_q) | (~reg_mode & y_int)) : '0;
  assign CFG_READY = ready_q;
  assign CFG_DONE  = done_q;

endmodule

// File: tb/tb_gal_olmc_bank_reg.sv
// Directed bench for gal_olmc_bank_reg with a 4-cell bank: fuse loading, stalls,
// reloads, restart and asynchronous reset, all checked against hand-computed values.
module tb_gal_olmc_bank_reg;

  localparam int N = 4;

  logic         C;
  logic         AR_N;
  logic [N-1:0] A;
  logic [N-1:0] Y;
  logic [N-1:0] FB;
  logic         CFG_START;
  logic         CFG_D;
  logic         CFG_VALID;
  logic         CFG_READY;
  logic         CFG_DONE;

  int n_checks = 0;
  int n_errors = 0;

  gal_olmc_bank_reg #(.N_OLMC(N), .CNT_W(5)) dut (
    .C         (C),
    .AR_N      (AR_N),
    .A         (A),
    .Y         (Y),
    .FB        (FB),
    .CFG_START (CFG_START),
    .CFG_D     (CFG_D),
    .CFG_VALID (CFG_VALID),
    .CFG_READY (CFG_READY),
    .CFG_DONE  (CFG_DONE)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge C);
    @(negedge C);
  endtask

  task automatic send_bit(input logic d);
    CFG_VALID = 1'b1;
    CFG_D     = d;
    tick();
    CFG_VALID = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] s, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(s[i]);
  endtask

  initial begin
    AR_N      = 1'b0;
    A         = '1;
    CFG_START = 1'b0;
    CFG_D     = 1'b0;
    CFG_VALID = 1'b0;
    @(negedge C);
    #1;
    check("rst_y",     32'(Y), 32'h0);
    check("rst_fb",    32'(FB), 32'h0);
    check("rst_done",  32'(CFG_DONE), 32'h0);
    check("rst_ready", 32'(CFG_READY), 32'h1);
    @(negedge C);
    AR_N = 1'b1;
    tick();
    check("nocfg_y",    32'(Y), 32'h0);
    check("nocfg_done", 32'(CFG_DONE), 32'h0);

    // All-zero stream: every cell combinational, non-inverting.
    send_bits(8'h00, 0, 7);
    check("z_apply_ready", 32'(CFG_READY), 32'h0);
    check("z_apply_done",  32'(CFG_DONE), 32'h0);
    tick();
    check("z_run_done",  32'(CFG_DONE), 32'h1);
    check("z_run_ready", 32'(CFG_READY), 32'h1);
    A = 4'hA;
    #1;
    check("z_y_a",  32'(Y), 32'hA);
    check("z_fb_a", 32'(FB), 32'hA);
    A = 4'h5;
    #1;
    check("z_y_comb", 32'(Y), 32'h5);

    // Reload with all-ones: registered and inverted everywhere.
    A = 4'hA;
    #1;
    send_bits(8'hFF, 0, 3);
    check("f_hold_y", 32'(Y), 32'hA);
    send_bits(8'hFF, 4, 7);
    check("f_apply_ready", 32'(CFG_READY), 32'h0);
    check("f_apply_y",     32'(Y), 32'hA);
    A = 4'h5;
    tick();
    check("f_clr_y",  32'(Y), 32'hF);
    check("f_clr_fb", 32'(FB), 32'h0);
    tick();
    check("f_run_y",     32'(Y), 32'hA);
    check("f_run_fb",    32'(FB), 32'h5);
    check("f_run_ready", 32'(CFG_READY), 32'h1);

    // Mixed stream 0x69 with a 10-cycle stall after 3 bits: reg=1001, inv=0110.
    send_bits(8'h69, 0, 2);
    for (int i = 0; i < 10; i++) tick();
    check("stall_ready", 32'(CFG_READY), 32'h1);
    send_bits(8'h69, 3, 6);
    check("stall_7_ready", 32'(CFG_READY), 32'h1);
    check("stall_7_done",  32'(CFG_DONE), 32'h1);
    send_bits(8'h69, 7, 7);
    check("stall_8_ready", 32'(CFG_READY), 32'h0);
    A = 4'b0011;
    tick();
    check("mix_y0",  32'(Y), 32'h4);
    check("mix_fb0", 32'(FB), 32'h4);
    tick();
    check("mix_y1",  32'(Y), 32'h5);
    check("mix_fb1", 32'(FB), 32'h5);
    A = 4'b1100;
    #1;
    check("mix_y_comb", 32'(Y), 32'h3);
    tick();
    check("mix_y2",  32'(Y), 32'hA);
    check("mix_fb2", 32'(FB), 32'hA);

    // Reload in RUN: the mixed behaviour holds until the APPLY edge.
    send_bits(8'h00, 0, 3);
    check("rl_mid_y", 32'(Y), 32'hA);
    send_bits(8'h00, 4, 7);
    check("rl_apply_y",    32'(Y), 32'hA);
    check("rl_apply_done", 32'(CFG_DONE), 32'h1);
    check("rl_apply_rdy",  32'(CFG_READY), 32'h0);
    tick();
    check("rl_new_y",  32'(Y), 32'hC);
    check("rl_new_fb", 32'(FB), 32'hC);

    // Five stray bits, then CFG_START with a valid bit: target stream 0x03.
    send_bits(8'hFF, 0, 4);
    CFG_START = 1'b1;
    send_bit(1'b1);
    CFG_START = 1'b0;
    send_bits(8'h03, 1, 2);
    check("st_3_ready", 32'(CFG_READY), 32'h1);
    send_bits(8'h03, 3, 6);
    check("st_7_ready", 32'(CFG_READY), 32'h1);
    send_bits(8'h03, 7, 7);
    check("st_8_ready", 32'(CFG_READY), 32'h0);
    A = 4'hF;
    tick();
    check("st_y0",  32'(Y), 32'hF);
    check("st_fb0", 32'(FB), 32'hE);
    tick();
    check("st_y1",  32'(Y), 32'hE);
    check("st_fb1", 32'(FB), 32'hF);

    // Asynchronous reset mid-stream clears outputs at once and discards the partial load.
    send_bits(8'h00, 0, 2);
    #2;
    AR_N = 1'b0;
    #1;
    check("ar_y",     32'(Y), 32'h0);
    check("ar_fb",    32'(FB), 32'h0);
    check("ar_done",  32'(CFG_DONE), 32'h0);
    check("ar_ready", 32'(CFG_READY), 32'h1);
    @(negedge C);
    AR_N = 1'b1;
    send_bits(8'h00, 0, 4);
    check("ar_5_ready", 32'(CFG_READY), 32'h1);
    check("ar_5_done",  32'(CFG_DONE), 32'h0);
    send_bits(8'h00, 5, 7);
    check("ar_8_ready", 32'(CFG_READY), 32'h0);
    tick();
    check("ar_run_done", 32'(CFG_DONE), 32'h1);
    check("ar_run_y",    32'(Y), 32'hF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
